// File: rtl/parity_rx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : parity_rx_pkg                                         |
// | Brief    : Shared types and constants for the parity frame       |
// |            receive path (FSM encoding, counter width, modes).    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package parity_rx_pkg;

  // Frame receiver states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Default word width and the matching bit-counter width
  localparam int DATA_W_DEFAULT = 8;
  localparam int CNT_W          = $clog2(DATA_W_DEFAULT);

  // Required XOR of {data, parity bit} for each parity mode
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Counter width for an arbitrary word width (at least one bit)
  function automatic int cnt_width(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_reducer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : parity_reducer                                        |
// | Brief    : Pure XOR reduction of a W-bit vector. Shared with the |
// |            existing parity-check path.                           |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module parity_reducer #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_vec,
  output logic         o_parity
);

  // Odd number of ones yields 1
  assign o_parity = ^i_vec;

endmodule
`default_nettype wire

// File: rtl/parity_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : parity_frame_rx                                       |
// | Brief    : Bit-strobed serial receiver: start, DATA_W data bits  |
// |            (LSB first), parity and optional stop bit. Parity is  |
// |            checked by XOR reduction and the frame is held in a   |
// |            one-entry valid/ready output buffer.                  |
// | Config   : define STOP_BIT_CHECK_EN to receive and check a stop  |
// |            bit; otherwise frames end on the parity bit and       |
// |            FrameErr is tied low.                                 |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              BitIn,
  input  logic              BitValid,
  output logic [DATA_W-1:0] DataOut,
  output logic              ParityErr,
  output logic              FrameErr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Overrun,
  output logic              Busy
);
  import parity_rx_pkg::*;

  localparam int                  CNT_BITS = cnt_width(DATA_W);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DATA_W - 1);
  localparam logic                EXP_XOR  = (PARITY_ODD != 0) ? parity_rx_pkg::PARITY_ODD
                                                               : PARITY_EVEN;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_w;
  logic                done_w;
  logic                par_bit_w;
  logic                xor_w;
  logic                perr_w;
`ifdef STOP_BIT_CHECK_EN
  logic                par_q, par_d;
  logic                ferr_q, ferr_d;
`endif

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only strobed cycles advance the frame
  always_comb begin
    state_d = state_q;
    if (BitValid) begin
      case (state_q)
        IDLE:    if (!BitIn) state_d = DATA;
        DATA:    if (cnt_q == LAST_CNT) state_d = PAR;
`ifdef STOP_BIT_CHECK_EN
        PAR:     state_d = STOP;
`else
        PAR:     state_d = IDLE;
`endif
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: busy flag and frame-complete strobe
  always_comb begin
    busy_w = (state_q != IDLE);
`ifdef STOP_BIT_CHECK_EN
    done_w = BitValid && (state_q == STOP);
`else
    done_w = BitValid && (state_q == PAR);
`endif
  end

  // Bit counter and shift register next values; new bits enter at the MSB
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (BitValid) begin
      case (state_q)
        IDLE: if (!BitIn) cnt_d = '0;
        DATA: begin
          shift_d = {BitIn, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Bit counter and shift register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

`ifdef STOP_BIT_CHECK_EN
  // Parity bit is held until the stop bit completes the frame
  always_comb begin
    par_d = par_q;
    if (BitValid && (state_q == PAR)) par_d = BitIn;
  end

  // Captured parity bit
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_bit_w = par_q;
`else
  // Without a stop bit the parity strobe itself completes the frame
  assign par_bit_w = BitIn;
`endif

  parity_reducer #(
    .W (DATA_W + 1)
  ) u_parity_reducer (
    .i_vec    ({shift_q, par_bit_w}),
    .o_parity (xor_w)
  );

  assign perr_w = (xor_w != EXP_XOR);

  // Output buffer: load when empty or being drained, else drop and flag overrun
  always_comb begin
    data_d    = data_q;
    perr_d    = perr_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
`ifdef STOP_BIT_CHECK_EN
    ferr_d    = ferr_q;
`endif
    if (done_w) begin
      if (!valid_q || OutReady) begin
        data_d  = shift_q;
        perr_d  = perr_w;
        valid_d = 1'b1;
`ifdef STOP_BIT_CHECK_EN
        ferr_d  = ~BitIn;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && OutReady) begin
      valid_d = 1'b0;
    end
  end

  // Output buffer registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data_q    <= '0;
      perr_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      perr_q    <= perr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef STOP_BIT_CHECK_EN
  // Stop-bit error flag for the buffered frame
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign FrameErr = ferr_q;
`else
  assign FrameErr = 1'b0;
`endif

  assign DataOut   = data_q;
  assign ParityErr = perr_q;
  assign OutValid  = valid_q;
  assign Overrun   = overrun_q;
  assign Busy      = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_parity_frame_rx                                    |
// | Brief    : Scoreboard bench for parity_frame_rx. Two instances   |
// |            (even and odd parity) share one bit stream; a frame   |
// |            model predicts buffer contents, OutValid and Overrun. |
// |            Honours STOP_BIT_CHECK_EN like the design.            |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_parity_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       out_ready;
  logic [7:0] dout0, dout1;
  logic       perr0, perr1, ferr0, ferr1;
  logic       ov0, ov1, ovr0, ovr1, busy0, busy1;

  typedef struct packed {
    logic [7:0] data;
    logic       perr_even;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_exp;
  logic cmp_flag;
  bit   rand_rdy;
  bit   m_valid;
  bit   m_ovr;
  int   n_cmp;
  int   n_fail;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
    .Clk(clk), .Rst_n(rst_n), .BitIn(bit_in), .BitValid(bit_valid),
    .DataOut(dout0), .ParityErr(perr0), .FrameErr(ferr0), .OutValid(ov0),
    .OutReady(out_ready), .Overrun(ovr0), .Busy(busy0)
  );

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .Clk(clk), .Rst_n(rst_n), .BitIn(bit_in), .BitValid(bit_valid),
    .DataOut(dout1), .ParityErr(perr1), .FrameErr(ferr1), .OutValid(ov1),
    .OutReady(out_ready), .Overrun(ovr1), .Busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a completed frame enters the buffer unless it is full and not read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      exp_q.delete();
    end else begin
      m_ovr = 1'b0;
      if (cmp_flag) begin
        if (!m_valid || out_ready) begin
          exp_q.push_back(cmp_exp);
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: compares both instances against the model every cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      check("reset_outs_even", 32'({dout0, perr0, ferr0, ov0, ovr0, busy0}), 32'd0);
      check("reset_outs_odd",  32'({dout1, perr1, ferr1, ov1, ovr1, busy1}), 32'd0);
    end else begin
      check("out_valid", 32'({ov1, ov0}), 32'({m_valid, m_valid}));
      check("overrun",   32'({ovr1, ovr0}), 32'({m_ovr, m_ovr}));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty: got OutValid with no expected frame at %0t", $time);
        end else begin
          e = exp_q[0];
          check("data_even", 32'(dout0), 32'(e.data));
          check("data_odd",  32'(dout1), 32'(e.data));
          check("perr_even", 32'(perr0), 32'(e.perr_even));
          check("perr_odd",  32'(perr1), 32'(!e.perr_even));
          check("frame_err", 32'({ferr1, ferr0}), 32'({e.ferr, e.ferr}));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus, driven just after the rising edge
  task automatic tick(input logic v, input logic b, input logic c);
    @(posedge clk);
    #1;
    bit_valid = v;
    bit_in    = b;
    cmp_flag  = c;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Random idle gap with a random (ignored) line value
  task automatic gap(input int maxgap);
    int n;
    n = $urandom_range(0, maxgap);
    for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int maxgap, input int idles, input bit rdy_last);
    exp_t e;
    e.data      = d;
    e.perr_even = (($countones({d, pb}) % 2) == 1);
`ifdef STOP_BIT_CHECK_EN
    e.ferr      = !sb;
`else
    e.ferr      = 1'b0;
`endif
    for (int i = 0; i < idles; i++) begin
      gap(maxgap);
      tick(1'b1, 1'b1, 1'b0);
    end
    gap(maxgap);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      gap(maxgap);
      tick(1'b1, d[i], 1'b0);
      if (i == 0) check("busy_in_frame", 32'({busy1, busy0}), 32'd3);
    end
    gap(maxgap);
    cmp_exp = e;
`ifdef STOP_BIT_CHECK_EN
    tick(1'b1, pb, 1'b0);
    gap(maxgap);
    tick(1'b1, sb, 1'b1);
`else
    tick(1'b1, pb, 1'b1);
`endif
    if (rdy_last) out_ready = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    check("busy_after_frame", 32'({busy1, busy0}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rand_rdy  = 0;
    cmp_flag  = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    cmp_exp   = '0;
    rst_n     = 1'b0;
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1'b0, 1'b1, 1'b0);

    // Directed frames: clean, parity error (even) / clean (odd), stop-bit error
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'h01, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0, 0);
    repeat (2) tick(1'b0, 1'b1, 1'b0);

    // Backpressure: second frame dropped, third loads while buffer is read
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'h33, 1'b0, 1'b1, 0, 0, 1);
    repeat (2) tick(1'b0, 1'b1, 1'b0);

    // Same word with and without gaps and idle-high strobes
    send_frame(8'hC3, 1'b0, 1'b1, 0, 0, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 5, 3, 0);

    // Reset after the fourth data bit, then a fresh frame
    out_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b1, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 0, 0);

    // Randomized frames, gaps and consumer backpressure
    rand_rdy = 1;
    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 3, $urandom_range(0, 2), 0);
    end
    rand_rdy  = 0;
    out_ready = 1'b1;
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    check("drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
